// File: rtl/cc_nestscan.sv
// Nest-pattern scan sequencer: walks the row index of an external row source and reports first hit and hit count.
// Optional macro CC_NESTSCAN_STOPONHIT_EN ends the scan on the first nest row.
module cc_nestscan #(
  parameter int NESTSCAN_DATAWIDTH  = 8,
  parameter int NESTSCAN_ROWS       = 8,
  parameter int NESTSCAN_ADDRWIDTH  = 3,
  parameter int NESTSCAN_COUNTWIDTH = 4
) (
  input  logic                           CC_NESTSCAN_CLOCK_50,
  input  logic                           CC_NESTSCAN_RESET_InHigh,
  input  logic                           CC_NESTSCAN_start_InHigh,
  input  logic [NESTSCAN_DATAWIDTH-1:0]  CC_NESTSCAN_data_InBUS,
  output logic [NESTSCAN_ADDRWIDTH-1:0]  CC_NESTSCAN_RowAddr_OutBUS,
  output logic                           CC_NESTSCAN_busy_OutHigh,
  output logic                           CC_NESTSCAN_done_OutHigh,
  output logic                           CC_NESTSCAN_hit_OutHigh,
  output logic [NESTSCAN_ADDRWIDTH-1:0]  CC_NESTSCAN_HitRow_OutBUS,
  output logic [NESTSCAN_COUNTWIDTH-1:0] CC_NESTSCAN_HitCount_OutBUS
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // SCAN  | one row evaluated per cycle
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  localparam logic [NESTSCAN_DATAWIDTH-1:0]  LP_NEST_A = NESTSCAN_DATAWIDTH'(8'h20);
  localparam logic [NESTSCAN_DATAWIDTH-1:0]  LP_NEST_B = NESTSCAN_DATAWIDTH'(8'h04);
  localparam logic [NESTSCAN_ADDRWIDTH-1:0]  LP_LAST   = NESTSCAN_ADDRWIDTH'(NESTSCAN_ROWS - 1);
  localparam logic [NESTSCAN_COUNTWIDTH-1:0] LP_ONE    = NESTSCAN_COUNTWIDTH'(1);

  state_t                           r_state;
  state_t                           w_next_state;
  logic [NESTSCAN_ADDRWIDTH-1:0]    r_row_addr;
  logic                             r_hit;
  logic [NESTSCAN_ADDRWIDTH-1:0]    r_hit_row;
  logic [NESTSCAN_COUNTWIDTH-1:0]   r_hit_count;
  logic                             w_nest_n;
  logic                             w_nest;
  logic                             w_last;
  logic                             w_stop;

  // Same match as the nest checker, whose output is active-low.
  assign w_nest_n = !((CC_NESTSCAN_data_InBUS == LP_NEST_A) ||
                      (CC_NESTSCAN_data_InBUS == LP_NEST_B));
  assign w_nest   = ~w_nest_n;
  assign w_last   = (r_row_addr == LP_LAST);

`ifdef CC_NESTSCAN_STOPONHIT_EN
  assign w_stop = w_last | w_nest;
`else
  assign w_stop = w_last;
`endif

  always_ff @(posedge CC_NESTSCAN_CLOCK_50 or posedge CC_NESTSCAN_RESET_InHigh) begin
    if (CC_NESTSCAN_RESET_InHigh) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (CC_NESTSCAN_start_InHigh) w_next_state = ST_SCAN;
      ST_SCAN: if (w_stop) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CC_NESTSCAN_CLOCK_50 or posedge CC_NESTSCAN_RESET_InHigh) begin
    if (CC_NESTSCAN_RESET_InHigh) begin
      r_row_addr  <= '0;
      r_hit       <= 1'b0;
      r_hit_row   <= '0;
      r_hit_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CC_NESTSCAN_start_InHigh) begin
            r_row_addr  <= '0;
            r_hit       <= 1'b0;
            r_hit_row   <= '0;
            r_hit_count <= '0;
          end
        end
        ST_SCAN: begin
          if (w_nest) begin
            r_hit_count <= r_hit_count + LP_ONE;
            if (!r_hit) begin
              r_hit     <= 1'b1;
              r_hit_row <= r_row_addr;
            end
          end
          // Address freezes on the terminating row so it reflects where the scan ended.
          if (!w_stop) r_row_addr <= r_row_addr + NESTSCAN_ADDRWIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign CC_NESTSCAN_RowAddr_OutBUS  = r_row_addr;
  assign CC_NESTSCAN_busy_OutHigh    = (r_state == ST_SCAN);
  assign CC_NESTSCAN_done_OutHigh    = (r_state == ST_DONE);
  assign CC_NESTSCAN_hit_OutHigh     = r_hit;
  assign CC_NESTSCAN_HitRow_OutBUS   = r_hit_row;
  assign CC_NESTSCAN_HitCount_OutBUS = r_hit_count;

endmodule

// File: tb/tb_cc_nestscan.sv
// Directed bench for cc_nestscan; expectations follow CC_NESTSCAN_STOPONHIT_EN when defined.
module tb_cc_nestscan;

`ifdef CC_NESTSCAN_STOPONHIT_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic [2:0] row_addr;
  logic       busy, done, hit;
  logic [2:0] hit_row;
  logic [3:0] hit_count;
  logic [7:0] rows [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always_comb data = rows[row_addr];

  cc_nestscan dut (
    .CC_NESTSCAN_CLOCK_50        (clk),
    .CC_NESTSCAN_RESET_InHigh    (rst),
    .CC_NESTSCAN_start_InHigh    (start),
    .CC_NESTSCAN_data_InBUS      (data),
    .CC_NESTSCAN_RowAddr_OutBUS  (row_addr),
    .CC_NESTSCAN_busy_OutHigh    (busy),
    .CC_NESTSCAN_done_OutHigh    (done),
    .CC_NESTSCAN_hit_OutHigh     (hit),
    .CC_NESTSCAN_HitRow_OutBUS   (hit_row),
    .CC_NESTSCAN_HitCount_OutBUS (hit_count)
  );

  task automatic fill_rows(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rows[i] = v;
  endtask

  // Cycle c is the clock period ending at edge c; edge 0 samples start. Returns at the negedge of the done cycle.
  task automatic start_and_wait(input bit hold, output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    if (!hold) #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; fill_rows(8'h00);
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy act=%0d exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done act=%0d exp=0", done); end
    total++; if (hit !== 1'b0)       begin bad++; $display("FAIL reset_hit act=%0d exp=0", hit); end
    total++; if (row_addr !== 3'd0)  begin bad++; $display("FAIL reset_addr act=%0d exp=0", row_addr); end
    total++; if (hit_row !== 3'd0)   begin bad++; $display("FAIL reset_hitrow act=%0d exp=0", hit_row); end
    total++; if (hit_count !== 4'd0) begin bad++; $display("FAIL reset_count act=%0d exp=0", hit_count); end
    rst = 1'b0;
  endtask

  task automatic test_no_hit;
    int dc, bc;
    fill_rows(8'h00);
    start_and_wait(1'b0, dc, bc);
    total++; if (dc != 9)            begin bad++; $display("FAIL nohit_done_cycle act=%0d exp=9", dc); end
    total++; if (bc != 8)            begin bad++; $display("FAIL nohit_busy_cycles act=%0d exp=8", bc); end
    total++; if (hit !== 1'b0)       begin bad++; $display("FAIL nohit_hit act=%0d exp=0", hit); end
    total++; if (hit_row !== 3'd0)   begin bad++; $display("FAIL nohit_hitrow act=%0d exp=0", hit_row); end
    total++; if (hit_count !== 4'd0) begin bad++; $display("FAIL nohit_count act=%0d exp=0", hit_count); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL nohit_idle done=%0d busy=%0d exp=0,0", done, busy); end
  endtask

  task automatic test_row5;
    int dc, bc;
    fill_rows(8'hFF); rows[5] = 8'h04;
    start_and_wait(1'b0, dc, bc);
    total++; if (dc != (STOP ? 7 : 9))           begin bad++; $display("FAIL row5_done_cycle act=%0d exp=%0d", dc, STOP ? 7 : 9); end
    total++; if (hit !== 1'b1)                   begin bad++; $display("FAIL row5_hit act=%0d exp=1", hit); end
    total++; if (hit_row !== 3'd5)               begin bad++; $display("FAIL row5_hitrow act=%0d exp=5", hit_row); end
    total++; if (hit_count !== 4'd1)             begin bad++; $display("FAIL row5_count act=%0d exp=1", hit_count); end
    total++; if (row_addr !== (STOP ? 3'd5 : 3'd7)) begin bad++; $display("FAIL row5_addr act=%0d exp=%0d", row_addr, STOP ? 5 : 7); end
    @(negedge clk);
    total++; if (hit_row !== 3'd5 || hit !== 1'b1) begin bad++; $display("FAIL row5_hold hit=%0d row=%0d exp=1,5", hit, hit_row); end
  endtask

  task automatic test_multi;
    int dc, bc;
    fill_rows(8'h00); rows[2] = 8'h20; rows[4] = 8'h24; rows[6] = 8'h04;
    start_and_wait(1'b0, dc, bc);
    total++; if (dc != (STOP ? 4 : 9))              begin bad++; $display("FAIL multi_done_cycle act=%0d exp=%0d", dc, STOP ? 4 : 9); end
    total++; if (hit !== 1'b1)                      begin bad++; $display("FAIL multi_hit act=%0d exp=1", hit); end
    total++; if (hit_row !== 3'd2)                  begin bad++; $display("FAIL multi_hitrow act=%0d exp=2", hit_row); end
    total++; if (hit_count !== (STOP ? 4'd1 : 4'd2)) begin bad++; $display("FAIL multi_count act=%0d exp=%0d", hit_count, STOP ? 1 : 2); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int dcount = 0;
    int dc = -1;
    fill_rows(8'h00);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin dcount++; dc = c; end
      start = (c == 3 || c == 9);
    end
    start = 1'b0;
    total++; if (dcount != 1)  begin bad++; $display("FAIL ignore_done_count act=%0d exp=1", dcount); end
    total++; if (dc != 9)      begin bad++; $display("FAIL ignore_done_cycle act=%0d exp=9", dc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy_after act=%0d exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int dc1, dc2, bc;
    fill_rows(8'h00); rows[0] = 8'h20;
    start_and_wait(1'b1, dc1, bc);
    total++; if (dc1 != (STOP ? 2 : 9))             begin bad++; $display("FAIL b2b_first_done act=%0d exp=%0d", dc1, STOP ? 2 : 9); end
    total++; if (hit !== 1'b1 || hit_count !== 4'd1 || hit_row !== 3'd0)
      begin bad++; $display("FAIL b2b_first_result hit=%0d cnt=%0d row=%0d exp=1,1,0", hit, hit_count, hit_row); end
    fill_rows(8'h00);
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b1)
      begin bad++; $display("FAIL b2b_idle busy=%0d done=%0d hit=%0d exp=0,0,1", busy, done, hit); end
    @(negedge clk);
    total++; if (busy !== 1'b1 || hit !== 1'b0 || hit_count !== 4'd0)
      begin bad++; $display("FAIL b2b_restart busy=%0d hit=%0d cnt=%0d exp=1,0,0", busy, hit, hit_count); end
    dc2 = -1;
    for (int c = dc1 + 2; c <= dc1 + 20; c++) begin
      if (done) begin dc2 = c; break; end
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (dc2 != dc1 + 10) begin bad++; $display("FAIL b2b_second_done act=%0d exp=%0d", dc2, dc1 + 10); end
    total++; if (hit !== 1'b0 || hit_count !== 4'd0)
      begin bad++; $display("FAIL b2b_second_result hit=%0d cnt=%0d exp=0,0", hit, hit_count); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dc, bc;
    int dcount = 0;
    int mr_row = STOP ? 6 : 1;
    fill_rows(8'h00); rows[mr_row] = 8'h04;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1 || hit !== !STOP)
      begin bad++; $display("FAIL mid_pre_reset busy=%0d hit=%0d exp=1,%0d", busy, hit, !STOP); end
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || row_addr !== 3'd0 || hit_row !== 3'd0 || hit_count !== 4'd0)
      begin bad++; $display("FAIL mid_async_reset busy=%0d done=%0d hit=%0d addr=%0d row=%0d cnt=%0d exp=all 0",
                            busy, done, hit, row_addr, hit_row, hit_count); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    total++; if (dcount != 0) begin bad++; $display("FAIL mid_no_done act=%0d exp=0", dcount); end
    start_and_wait(1'b0, dc, bc);
    total++; if (dc != (STOP ? mr_row + 2 : 9)) begin bad++; $display("FAIL mid_fresh_done act=%0d exp=%0d", dc, STOP ? mr_row + 2 : 9); end
    total++; if (hit !== 1'b1 || hit_row !== 3'(mr_row) || hit_count !== 4'd1)
      begin bad++; $display("FAIL mid_fresh_result hit=%0d row=%0d cnt=%0d exp=1,%0d,1", hit, hit_row, hit_count, mr_row); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_hit();
    test_row5();
    test_multi();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
